// File: rtl/lsu.sv
// Load/store unit: turns one core request at a time into a byte-masked, lane-aligned
// data-memory access with a bounded wait. Optional misalignment trap: MISALIGN_TRAP_EN.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | strobes asserted, waiting on ip_data_valid or the timeout
//   RESP  | one-cycle response pulse
module lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ip_req_valid,
    output logic              op_req_ready,
    input  logic              ip_req_wr,
    input  logic [2:0]        ip_req_funct3,
    input  logic [XLEN-1:0]   ip_req_addr,
    input  logic [XLEN-1:0]   ip_req_wdata,
    output logic              op_resp_valid,
    output logic [XLEN-1:0]   op_resp_rdata,
    output logic              op_resp_err,
    output logic [XLEN-1:0]   op_data_addr,
    output logic              op_data_wr,
    output logic              op_data_rd,
    output logic [XLEN/8-1:0] op_data_mask,
    output logic [XLEN-1:0]   op_data_from_proc,
    input  logic              ip_data_valid,
    input  logic [XLEN-1:0]   ip_data_from_dmem
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam logic [XLEN-1:0] LANE_MASK = XLEN'(NB - 1);
    localparam logic [7:0]      TO_CNT    = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;

    logic              ready_d, resp_valid_d, resp_err_d, wr_d, rd_d;
    logic [XLEN-1:0]   rdata_d, addr_d, wdata_d;
    logic [NB-1:0]     mask_d;

    logic [1:0]        req_size;
    logic [2:0]        req_low;
    logic              req_illegal, req_fault;
    logic [XLEN-1:0]   req_addr, req_wdata;
    logic [LANE_W-1:0] req_lane;
    logic [NB-1:0]     req_ones, req_mask;

    logic [XLEN-1:0]   ld_shift, ld_keep, ld_ext;
    logic              ld_sign;
    int                ld_bits;

    always_comb begin
        req_size    = ip_req_funct3[1:0];
        req_low     = {req_size == 2'd3, req_size[1], |req_size};
        req_illegal = (ip_req_funct3 == 3'b111)
                   || (ip_req_wr && ip_req_funct3[2])
                   || ((XLEN == 32) && ((ip_req_funct3 == 3'b011) || (ip_req_funct3 == 3'b110)));
`ifdef MISALIGN_TRAP_EN
        req_fault   = req_illegal || (|(ip_req_addr[2:0] & req_low));
`else
        req_fault   = req_illegal;
`endif
        // Without the trap, sub-size address bits are dropped so the access is natural.
        req_addr    = ip_req_addr & ~XLEN'(req_low);
        req_lane    = req_addr[LANE_W-1:0];
        for (int i = 0; i < NB; i++) begin
            req_ones[i] = (i < (1 << req_size));
        end
        req_mask    = req_ones << req_lane;
        req_wdata   = ip_req_wdata << {req_lane, 3'b000};
    end

    always_comb begin
        ld_shift = ip_data_from_dmem >> {lane_q, 3'b000};
        ld_bits  = 8 << size_q;
        ld_sign  = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            ld_keep[i] = (i < ld_bits);
            if (i == ld_bits - 1) ld_sign = ld_shift[i];
        end
        ld_ext = (ld_shift & ld_keep) | ((ld_sign && !uns_q) ? ~ld_keep : '0);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        size_d       = size_q;
        uns_d        = uns_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = '0;
        wr_d         = op_data_wr;
        rd_d         = op_data_rd;
        addr_d       = op_data_addr;
        mask_d       = op_data_mask;
        wdata_d      = op_data_from_proc;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ip_req_valid) begin
                    ready_d = 1'b0;
                    if (req_fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 8'd1;
                        lane_d  = req_lane;
                        size_d  = req_size;
                        uns_d   = ip_req_funct3[2];
                        addr_d  = req_addr & ~LANE_MASK;
                        mask_d  = req_mask;
                        wdata_d = req_wdata;
                        wr_d    = ip_req_wr;
                        rd_d    = !ip_req_wr;
                    end
                end
            end
            WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (ip_data_valid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    wr_d         = 1'b0;
                    rd_d         = 1'b0;
                    if (op_data_rd) rdata_d = ld_ext;
                end else if (cnt_q == TO_CNT) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    wr_d         = 1'b0;
                    rd_d         = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                wr_d    = 1'b0;
                rd_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            lane_q            <= '0;
            size_q            <= '0;
            uns_q             <= 1'b0;
            op_req_ready      <= 1'b1;
            op_resp_valid     <= 1'b0;
            op_resp_err       <= 1'b0;
            op_resp_rdata     <= '0;
            op_data_wr        <= 1'b0;
            op_data_rd        <= 1'b0;
            op_data_addr      <= '0;
            op_data_mask      <= '0;
            op_data_from_proc <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            lane_q            <= lane_d;
            size_q            <= size_d;
            uns_q             <= uns_d;
            op_req_ready      <= ready_d;
            op_resp_valid     <= resp_valid_d;
            op_resp_err       <= resp_err_d;
            op_resp_rdata     <= rdata_d;
            op_data_wr        <= wr_d;
            op_data_rd        <= rd_d;
            op_data_addr      <= addr_d;
            op_data_mask      <= mask_d;
            op_data_from_proc <= wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a 32-bit unit with TIMEOUT=4 checked through a response
// scoreboard, plus a 64-bit unit for wide lanes and D/WU loads.
module tb_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid = 1'b0, req_wr = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rdy, resp_valid, resp_err, d_wr, d_rd;
    logic [31:0] rdata, d_addr, d_wdata;
    logic [3:0]  d_mask;
    logic        d_valid = 1'b0;
    logic [31:0] d_rdata = '0;

    logic        w_valid = 1'b0;
    logic [2:0]  w_f3 = 3'd0;
    logic [63:0] w_addr = '0;
    logic        w_rdy, w_rvalid, w_rerr, w_dwr, w_drd;
    logic [63:0] w_rdata, w_daddr, w_dwdata;
    logic [7:0]  w_dmask;
    logic        w_dvalid = 1'b0;
    logic [63:0] w_drdata = '0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .ip_req_valid(req_valid), .op_req_ready(rdy), .ip_req_wr(req_wr),
        .ip_req_funct3(f3), .ip_req_addr(addr), .ip_req_wdata(wdata),
        .op_resp_valid(resp_valid), .op_resp_rdata(rdata), .op_resp_err(resp_err),
        .op_data_addr(d_addr), .op_data_wr(d_wr), .op_data_rd(d_rd),
        .op_data_mask(d_mask), .op_data_from_proc(d_wdata),
        .ip_data_valid(d_valid), .ip_data_from_dmem(d_rdata)
    );

    lsu #(.XLEN(64), .TIMEOUT(15)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .ip_req_valid(w_valid), .op_req_ready(w_rdy), .ip_req_wr(1'b0),
        .ip_req_funct3(w_f3), .ip_req_addr(w_addr), .ip_req_wdata(64'd0),
        .op_resp_valid(w_rvalid), .op_resp_rdata(w_rdata), .op_resp_err(w_rerr),
        .op_data_addr(w_daddr), .op_data_wr(w_dwr), .op_data_rd(w_drd),
        .op_data_mask(w_dmask), .op_data_from_proc(w_dwdata),
        .ip_data_valid(w_dvalid), .ip_data_from_dmem(w_drdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexp_resp", {63'd0, resp_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
                chk("resp_rdata", {32'd0, rdata}, {32'd0, mon_e.rdata});
            end
        end
    end

    // waits < 0: memory never answers. Entered and left just after a rising edge.
    task automatic rq(input bit wr, input logic [2:0] fn, input logic [31:0] a,
                      input logic [31:0] wd, input int waits, input logic [31:0] md,
                      input bit flt, input logic [31:0] er, input logic [3:0] em,
                      input logic [31:0] ea, input logic [31:0] ew);
        int lim;
        int n;
        bit e;
        e = flt || (waits < 0);
        sb.push_back({e, (e || wr) ? 32'd0 : er});
        req_valid = 1'b1; req_wr = wr; f3 = fn; addr = a; wdata = wd;
        @(negedge clk);
        chk("ready", {63'd0, rdy}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (flt) begin
            @(negedge clk);
            chk("fault_lat", {63'd0, resp_valid}, 64'd1);
            chk("fault_nostrobe", {62'd0, d_wr, d_rd}, 64'd0);
        end else begin
            lim = (waits < 0) ? TO : waits + 1;
            n = 0;
            for (int c = 0; c < lim; c++) begin
                if (c == waits) begin
                    d_valid = 1'b1;
                    d_rdata = md;
                end
                @(negedge clk);
                n += int'(wr ? d_wr : d_rd);
                chk("other_strobe", {63'd0, wr ? d_rd : d_wr}, 64'd0);
                chk("busy", {63'd0, rdy}, 64'd0);
                chk("mask", {60'd0, d_mask}, {60'd0, em});
                chk("daddr", {32'd0, d_addr}, {32'd0, ea});
                chk("dwdata", {32'd0, d_wdata}, {32'd0, ew});
                @(posedge clk); #1;
                d_valid = 1'b0;
            end
            @(negedge clk);
            chk("resp_lat", {63'd0, resp_valid}, 64'd1);
            chk("strobe_drop", {62'd0, d_wr, d_rd}, 64'd0);
            chk("strobe_cycles", 64'(n), 64'(lim));
        end
        @(posedge clk); #1;
    endtask

    task automatic rq64(input logic [2:0] fn, input logic [63:0] a, input logic [63:0] md,
                        input logic [63:0] er, input logic [7:0] em, input logic [63:0] ea);
        w_valid = 1'b1; w_f3 = fn; w_addr = a;
        @(posedge clk); #1;
        w_valid = 1'b0; w_dvalid = 1'b1; w_drdata = md;
        @(negedge clk);
        chk("w_rd", {63'd0, w_drd}, 64'd1);
        chk("w_mask", {56'd0, w_dmask}, {56'd0, em});
        chk("w_daddr", w_daddr, ea);
        @(posedge clk); #1;
        w_dvalid = 1'b0;
        @(negedge clk);
        chk("w_resp", {63'd0, w_rvalid}, 64'd1);
        chk("w_err", {63'd0, w_rerr}, 64'd0);
        chk("w_rdata", w_rdata, er);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_ready", {63'd0, rdy}, 64'd1);
        chk("rst_resp", {62'd0, resp_valid, resp_err}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_strobes", {62'd0, d_wr, d_rd}, 64'd0);
        chk("rst_daddr", {32'd0, d_addr}, 64'd0);
        chk("rst_mask", {60'd0, d_mask}, 64'd0);
        chk("rst_dwdata", {32'd0, d_wdata}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        rq(0, 3'b000, 32'h1003, 32'h0, 0, 32'h80FF_FF00, 0, 32'hFFFF_FF80, 4'b1000, 32'h1000, 32'h0);
        rq(1, 3'b001, 32'h2002, 32'h0000_ABCD, 3, 32'h0, 0, 32'h0, 4'b1100, 32'h2000, 32'hABCD_0000);
        rq(0, 3'b010, 32'h3000, 32'h0, -1, 32'h0, 0, 32'h0, 4'b1111, 32'h3000, 32'h0);
        rq(0, 3'b010, 32'h3004, 32'h0, 3, 32'h1234_5678, 0, 32'h1234_5678, 4'b1111, 32'h3004, 32'h0);
`ifdef MISALIGN_TRAP_EN
        rq(0, 3'b010, 32'h1001, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
        rq(0, 3'b001, 32'h1003, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
`else
        rq(0, 3'b010, 32'h1001, 32'h0, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b1111, 32'h1000, 32'h0);
        rq(0, 3'b001, 32'h1003, 32'h0, 0, 32'h7F01_0000, 0, 32'h0000_7F01, 4'b1100, 32'h1000, 32'h0);
`endif
        rq(0, 3'b011, 32'h0010, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
        rq(1, 3'b100, 32'h0010, 32'h5, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
        rq(0, 3'b111, 32'h0010, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
        rq(0, 3'b110, 32'h0010, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
        rq(0, 3'b101, 32'h0002, 32'h0, 1, 32'h8001_0000, 0, 32'h0000_8001, 4'b1100, 32'h0, 32'h0);
        rq(0, 3'b001, 32'h0002, 32'h0, 0, 32'h8001_0000, 0, 32'hFFFF_8001, 4'b1100, 32'h0, 32'h0);
        rq(1, 3'b000, 32'h5001, 32'h0000_00A5, 0, 32'h0, 0, 32'h0, 4'b0010, 32'h5000, 32'h0000_A500);
        rq(0, 3'b100, 32'h0000, 32'h0, 0, 32'h0000_00F0, 0, 32'h0000_00F0, 4'b0001, 32'h0, 32'h0);
        rq(1, 3'b010, 32'h6008, 32'hDEAD_BEEF, 2, 32'h0, 0, 32'h0, 4'b1111, 32'h6008, 32'hDEAD_BEEF);

        // Reset in the middle of a WAIT: abandoned access, nothing pushed to the scoreboard.
        req_valid = 1'b1; req_wr = 1'b0; f3 = 3'b010; addr = 32'h4000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_rd", {63'd0, d_rd}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async_rd", {63'd0, d_rd}, 64'd0);
        chk("rst_async_ready", {63'd0, rdy}, 64'd1);
        chk("rst_async_resp", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_ready", {63'd0, rdy}, 64'd1);
            chk("post_rst_strobe", {62'd0, d_wr, d_rd}, 64'd0);
        end
        @(posedge clk); #1;
        rq(0, 3'b011, 32'h0008, 32'h0, 0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 32'h0);

        rq64(3'b110, 64'h0C, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 8'hF0, 64'h8);
        rq64(3'b011, 64'h10, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h10);
        rq64(3'b010, 64'h04, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 8'hF0, 64'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
